// File: rtl/wb_stage.sv
// wb_stage: writeback stage that feeds the register file write/clear port and resolves loads over a req/ack port.
// Optional load timeout is built only when WB_MEM_TIMEOUT_EN is defined.
module wb_stage #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 3,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [ADDR_W-1:0] ex_rd,
   input  logic [DATA_W-1:0] ex_result,
   input  logic              ex_we,
   input  logic              ex_is_load,
   input  logic              ex_byte,
   input  logic              ex_clear,
   output logic              mem_req,
   output logic [DATA_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] WB_addr,
   output logic [DATA_W-1:0] WB_data,
   output logic              RegWe,
   output logic              reg_clear,
   output logic              load_err
);

   typedef enum logic [0:0] {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

   state_t            state_r, nxt_state_s;
   logic              nxt_ex_ready_s;
   logic              nxt_mem_req_s;
   logic [DATA_W-1:0] nxt_mem_addr_s;
   logic [ADDR_W-1:0] nxt_wb_addr_s;
   logic [DATA_W-1:0] nxt_wb_data_s;
   logic              nxt_reg_we_s;
   logic              nxt_reg_clear_s;
   logic              nxt_load_err_s;
   logic [ADDR_W-1:0] ld_rd_r, nxt_ld_rd_s;
   logic              ld_byte_r, nxt_ld_byte_s;
   logic              ld_sel_r, nxt_ld_sel_s;

`ifdef WB_MEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(MEM_TIMEOUT + 1) < 4) ? 4 : $clog2(MEM_TIMEOUT + 1);
   logic [CNT_W-1:0] wait_cnt_r, nxt_wait_cnt_s;
`endif

   if (MEM_TIMEOUT < 1) begin : g_cfg_check
      $error("wb_stage: MEM_TIMEOUT must be at least 1");
   end

   // Byte loads are zero-extended; the latched address bit picks the high or low byte.
   function automatic logic [DATA_W-1:0] load_data(input logic [DATA_W-1:0] rdata,
                                                   input logic              is_byte,
                                                   input logic              sel);
      if (is_byte) begin
         if (sel) begin
            load_data = {{(DATA_W-8){1'b0}}, rdata[15:8]};
         end else begin
            load_data = {{(DATA_W-8){1'b0}}, rdata[7:0]};
         end
      end else begin
         load_data = rdata;
      end
   endfunction

   // Next-state and next-output decode.
   always_comb begin
      nxt_state_s     = state_r;
      nxt_ex_ready_s  = ex_ready;
      nxt_mem_req_s   = mem_req;
      nxt_mem_addr_s  = mem_addr;
      nxt_wb_addr_s   = WB_addr;
      nxt_wb_data_s   = WB_data;
      nxt_reg_we_s    = 1'b0;
      nxt_reg_clear_s = 1'b0;
      nxt_load_err_s  = 1'b0;
      nxt_ld_rd_s     = ld_rd_r;
      nxt_ld_byte_s   = ld_byte_r;
      nxt_ld_sel_s    = ld_sel_r;
`ifdef WB_MEM_TIMEOUT_EN
      nxt_wait_cnt_s  = wait_cnt_r;
`endif
      case (state_r)
         IDLE: begin
            if (ex_valid && ex_ready) begin
               if (ex_clear) begin
                  // Clear takes priority; any write or load riding with it is dropped.
                  nxt_reg_clear_s = 1'b1;
               end else if (ex_we && ex_is_load) begin
                  nxt_mem_req_s  = 1'b1;
                  nxt_mem_addr_s = {ex_result[DATA_W-1:1], 1'b0};
                  nxt_ld_rd_s    = ex_rd;
                  nxt_ld_byte_s  = ex_byte;
                  nxt_ld_sel_s   = ex_result[0];
                  nxt_ex_ready_s = 1'b0;
                  nxt_state_s    = WAIT_MEM;
`ifdef WB_MEM_TIMEOUT_EN
                  nxt_wait_cnt_s = {CNT_W{1'b0}};
`endif
               end else if (ex_we) begin
                  nxt_reg_we_s  = (ex_rd != {ADDR_W{1'b0}});
                  nxt_wb_addr_s = ex_rd;
                  nxt_wb_data_s = ex_result;
               end else begin
                  nxt_reg_we_s = 1'b0;
               end
            end else begin
               nxt_reg_we_s = 1'b0;
            end
         end
         WAIT_MEM: begin
            if (mem_ack) begin
               nxt_mem_req_s  = 1'b0;
               nxt_ex_ready_s = 1'b1;
               nxt_state_s    = IDLE;
               nxt_reg_we_s   = (ld_rd_r != {ADDR_W{1'b0}});
               nxt_wb_addr_s  = ld_rd_r;
               nxt_wb_data_s  = load_data(mem_rdata, ld_byte_r, ld_sel_r);
            end else begin
`ifdef WB_MEM_TIMEOUT_EN
               // The increment that would reach MEM_TIMEOUT abandons the load instead.
               if (wait_cnt_r == CNT_W'(MEM_TIMEOUT - 1)) begin
                  nxt_load_err_s = 1'b1;
                  nxt_mem_req_s  = 1'b0;
                  nxt_ex_ready_s = 1'b1;
                  nxt_state_s    = IDLE;
               end else begin
                  nxt_wait_cnt_s = wait_cnt_r + CNT_W'(1);
               end
`else
               nxt_mem_req_s = 1'b1;
`endif
            end
         end
         default: begin
            nxt_state_s    = IDLE;
            nxt_ex_ready_s = 1'b1;
            nxt_mem_req_s  = 1'b0;
         end
      endcase
   end

   // State, latched load context and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         ex_ready   <= 1'b1;
         mem_req    <= 1'b0;
         mem_addr   <= {DATA_W{1'b0}};
         WB_addr    <= {ADDR_W{1'b0}};
         WB_data    <= {DATA_W{1'b0}};
         RegWe      <= 1'b0;
         reg_clear  <= 1'b0;
         load_err   <= 1'b0;
         ld_rd_r    <= {ADDR_W{1'b0}};
         ld_byte_r  <= 1'b0;
         ld_sel_r   <= 1'b0;
`ifdef WB_MEM_TIMEOUT_EN
         wait_cnt_r <= {CNT_W{1'b0}};
`endif
      end else begin
         state_r    <= nxt_state_s;
         ex_ready   <= nxt_ex_ready_s;
         mem_req    <= nxt_mem_req_s;
         mem_addr   <= nxt_mem_addr_s;
         WB_addr    <= nxt_wb_addr_s;
         WB_data    <= nxt_wb_data_s;
         RegWe      <= nxt_reg_we_s;
         reg_clear  <= nxt_reg_clear_s;
         load_err   <= nxt_load_err_s;
         ld_rd_r    <= nxt_ld_rd_s;
         ld_byte_r  <= nxt_ld_byte_s;
         ld_sel_r   <= nxt_ld_sel_s;
`ifdef WB_MEM_TIMEOUT_EN
         wait_cnt_r <= nxt_wait_cnt_s;
`endif
      end
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 16-bit CPU pipeline, directly upstream of the 8-entry register file.
- Accepts one retiring instruction per cycle from execute and resolves loads through a simple req/ack data-memory port.
- Drives the register file's write port (WB_addr, WB_data, RegWe) and its clear request (reg_clear).
- Stalls execute via ex_ready while a load is outstanding.

Parameters:
- DATA_W, 16, datapath width; matches register file width.
- ADDR_W, 3, register index width (8 registers).
- MEM_TIMEOUT, 15, max cycles to wait for mem_ack. Only used when WB_MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: one clock; reset is asynchronous and active-high.
- ex_valid  in  1  execute presents a retiring instruction.
- ex_ready  out  1  stage can accept; transfer when ex_valid && ex_ready.
- ex_rd  in  ADDR_W  destination register.
- ex_result  in  DATA_W  ALU result; byte address for loads.
- ex_we  in  1  instruction writes ex_rd.
- ex_is_load  in  1  result comes from memory.
- ex_byte  in  1  byte load (else word load).
- ex_clear  in  1  request clear of whole register file.
- mem_req  out  1  load request, held until ack.
- mem_addr  out  DATA_W  load address (word-aligned: bit 0 forced 0).
- mem_ack  in  1  one-cycle response strobe, valid only while mem_req=1.
- mem_rdata  in  DATA_W  load data, valid with mem_ack.
- WB_addr  out  ADDR_W  register file write index.
- WB_data  out  DATA_W  register file write data.
- RegWe  out  1  register file write enable, one-cycle pulse per write.
- reg_clear  out  1  one-cycle register file clear pulse.
- load_err  out  1  one-cycle pulse on load timeout.

Behaviour:
- Reset values: ex_ready=1; mem_req=0; mem_addr=0; WB_addr=0; WB_data=0; RegWe=0; reg_clear=0; load_err=0; FSM=IDLE. All outputs are registered.
- FSM states are IDLE and WAIT_MEM.
- IDLE: ex_ready=1. On transfer:
  - ex_clear=1: reg_clear=1 next cycle, RegWe=0. Clear wins over a simultaneous write or load; the write/load is dropped.
  - ex_is_load=1 and ex_we=1: mem_req=1 and mem_addr={ex_result[15:1],1'b0} next cycle. Latch ex_rd, ex_byte and ex_result[0]. Go to WAIT_MEM.
  - ex_we=1, non-load: next cycle RegWe=1, WB_addr=ex_rd, WB_data=ex_result. Latency 1; sustains one write per cycle back-to-back.
  - ex_we=0 (and no clear): no output activity.
  - ex_rd==0: RegWe suppressed (r0 is read-only). A load with rd=0 still issues the memory request, for side effects.
- WAIT_MEM: ex_ready=0; mem_req held high and mem_addr stable.
  - On mem_ack: next cycle mem_req=0, FSM=IDLE, RegWe=1 (unless rd=0), WB_addr=latched rd.
  - WB_data = mem_rdata for word loads.
  - For byte loads, WB_data = {8'h00, selected byte}: byte select 0 takes mem_rdata[7:0], select 1 takes mem_rdata[15:8].
  - ex_ready returns to 1 in that same cycle. A new instruction accepted then writes one cycle after the load's write, so ordering is preserved.
- mem_ack while mem_req=0 is ignored.
- RegWe, reg_clear and load_err are high for exactly one cycle per event; they are never high together.
- Async reset mid-load: mem_req drops immediately, FSM=IDLE, pending write discarded, no RegWe.

Optional Feature:
- Macro: WB_MEM_TIMEOUT_EN.
- Defined:
  - A 4-bit (minimum) counter clears on entry to WAIT_MEM and increments each WAIT_MEM cycle without ack.
  - If the counter reaches MEM_TIMEOUT without ack: next cycle load_err=1 for one cycle, mem_req=0, FSM=IDLE, no RegWe.
  - An ack arriving in the same cycle the limit is reached wins; the load completes normally.
- Undefined: no counter; WAIT_MEM is held indefinitely; load_err is tied to 0.

Test Plan:
- ALU back-to-back:
  - Stimulus: transfers (rd=3, 16'h1234) then (rd=5, 16'hBEEF) on consecutive cycles.
  - Required: RegWe high two consecutive cycles, WB_addr/WB_data = 3/1234 then 5/BEEF.
- Word load:
  - Stimulus: rd=2, ex_result=16'h0041, ack after 3 cycles with rdata=16'hA55A.
  - Required: mem_addr=16'h0040; ex_ready=0 throughout the wait; RegWe=1, WB_data=16'hA55A, WB_addr=2 the cycle after ack.
- Byte load:
  - Stimulus: ex_result=16'h0011, rdata=16'hC37E.
  - Required: WB_data=16'h00C3. With ex_result=16'h0010, WB_data=16'h007E.
- r0 / clear:
  - Stimulus: ALU write with rd=0.
  - Required: RegWe stays 0.
  - Stimulus: ex_clear=1 with ex_we=1, rd=4.
  - Required: reg_clear pulses one cycle, RegWe=0.
- Reset mid-load:
  - Stimulus: assert rst in WAIT_MEM.
  - Required: mem_req=0 immediately, ex_ready=1, no RegWe after release even if a stale ack arrives.
- Timeout (WB_MEM_TIMEOUT_EN):
  - Stimulus: load with no ack.
  - Required: load_err pulses after 15 wait cycles, mem_req drops, ex_ready=1, RegWe=0.
